// File: rtl/ram_write_buffer.sv
// ram_write_buffer: posted-write FIFO between the RAM cache and a single-port
// synchronous RAM. Cache write-throughs are queued and drained to RAM in
// cycles without a read; reads that hit a queued address are forwarded from
// the buffer so RAM ordering is never violated.
// Build option: define WB_COALESCE_EN to merge a write into an existing entry
// with the same address instead of taking a new slot.

module ram_write_buffer #(
  parameter int DATA_WIDTH         = 16,
  parameter int RAM_REGISTER_COUNT = 1024,
  parameter int DEPTH              = 4,
  localparam int AW                = $clog2(RAM_REGISTER_COUNT),
  localparam int PW                = $clog2(DEPTH),
  localparam int CW                = PW + 1
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic [DATA_WIDTH-1:0] up_out_m,
  input  logic                  up_write_m,
  input  logic                  up_read_m,
  input  logic [AW-1:0]         up_data_addr,
  output logic [DATA_WIDTH-1:0] up_in_m,
  output logic                  up_stall,
  input  logic [DATA_WIDTH-1:0] ram_in_m,
  output logic [DATA_WIDTH-1:0] ram_out_m,
  output logic                  ram_write_m,
  output logic [AW-1:0]         ram_data_addr,
  output logic                  wb_empty,
  output logic [CW-1:0]         wb_count
);

  typedef logic [PW-1:0] ptr_t;

  // FIFO storage; contents are don't-care after reset
  logic [AW-1:0]         addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  ptr_t          head_q, head_d;
  ptr_t          tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q;

  logic full_s;
  logic drain_s;
  logic enq_s;
  logic coal_s;
  logic fwd_hit_s;
  ptr_t fwd_idx_s;

  // Youngest-match search across valid entries, oldest to youngest
  always_comb begin
    ptr_t slot_v;
    slot_v    = head_q;
    fwd_hit_s = 1'b0;
    fwd_idx_s = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      slot_v = head_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_mem_q[slot_v] == up_data_addr)) begin
        fwd_hit_s = 1'b1;
        fwd_idx_s = slot_v;
      end else begin
        fwd_hit_s = fwd_hit_s;
      end
    end
  end

  // Accept/drain decisions and next-state pointer arithmetic
  always_comb begin
    full_s  = (count_q == CW'(DEPTH));
    // the RAM port belongs to the read whenever one is requested
    drain_s = !up_read_m && (count_q != {CW{1'b0}});
`ifdef WB_COALESCE_EN
    // merging into the head being drained this cycle would lose the write
    coal_s  = up_write_m && fwd_hit_s && !(drain_s && (fwd_idx_s == head_q));
`else
    coal_s  = 1'b0;
`endif
    // full is judged on the current count, so a drain frees space next cycle
    enq_s    = up_write_m && !coal_s && !full_s;
    up_stall = up_write_m && !coal_s && full_s;

    head_d = drain_s ? (head_q + PW'(1)) : head_q;
    tail_d = enq_s   ? (tail_q + PW'(1)) : tail_q;

    if (enq_s && !drain_s) begin
      count_d = count_q + CW'(1);
    end else if (drain_s && !enq_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // RAM port steering and read-data forwarding
  always_comb begin
    if (drain_s) begin
      ram_write_m   = 1'b1;
      ram_data_addr = addr_mem_q[head_q];
      ram_out_m     = data_mem_q[head_q];
    end else begin
      ram_write_m   = 1'b0;
      ram_data_addr = up_data_addr;
      ram_out_m     = {DATA_WIDTH{1'b0}};
    end

    // a write in the same cycle is the youngest value for this address
    if (up_write_m && up_read_m) begin
      up_in_m = up_out_m;
    end else if (fwd_hit_s) begin
      up_in_m = data_mem_q[fwd_idx_s];
    end else begin
      up_in_m = ram_in_m;
    end
  end

  // Pointer, occupancy and status registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      empty_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      empty_q <= (count_d == {CW{1'b0}});
    end
  end

  // Entry storage: fill the tail on enqueue, patch data on a coalescing hit
  always_ff @(posedge clk) begin
    if (enq_s) begin
      addr_mem_q[tail_q] <= up_data_addr;
      data_mem_q[tail_q] <= up_out_m;
    end else if (coal_s) begin
      data_mem_q[fwd_idx_s] <= up_out_m;
    end
  end

  assign wb_empty = empty_q;
  assign wb_count = count_q;

endmodule

// File: doc/ram_write_buffer.md
Name: ram_write_buffer

Overview:
Posted-write buffer between the RAM cache and the single-port synchronous RAM. It absorbs cache write-throughs into a small FIFO and drains them to RAM in cycles the read path leaves idle. Reads to addresses still held in the buffer are forwarded from it, so ordering against RAM is never violated. Upstream ports mirror the cache's RAM-side ports, and downstream ports drive the RAM directly.

Parameters:
DATA_WIDTH, 16, data word width
RAM_REGISTER_COUNT, 1024, RAM words; address width AW = $clog2(RAM_REGISTER_COUNT)
DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock
resetN  in  1  asynchronous active-low reset
up_out_m  in  DATA_WIDTH  write data from cache
up_write_m  in  1  write request
up_read_m  in  1  read request
up_data_addr  in  AW  request address
up_in_m  out  DATA_WIDTH  read data to cache
up_stall  out  1  write not accepted this cycle; upstream holds its request
ram_in_m  in  DATA_WIDTH  RAM read data, 1-cycle latency
ram_out_m  out  DATA_WIDTH  RAM write data
ram_write_m  out  1  RAM write strobe
ram_data_addr  out  AW  RAM address
wb_empty  out  1  FIFO empty
wb_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset is resetN, asynchronous, active-low, and the clock is clk. Reset sets head, tail and count to 0, wb_empty=1 and wb_count=0, and drives ram_write_m=0 and up_stall=0. Entry contents are don't-care.
- Storage is a DEPTH-entry register FIFO of {addr, data}. Head and tail wrap modulo DEPTH. The count distinguishes full from empty.
- Write accept: up_write_m && count<DEPTH enqueues {up_data_addr, up_out_m} at tail on the clock edge. When full, up_stall=1 and nothing is enqueued.
- A full FIFO does not accept a write in the same cycle as a drain. The entry freed by that drain is usable the next cycle.
- up_stall is combinational: up_write_m && full (modified by the Optional Feature).
- Read priority: while up_read_m=1, the RAM port serves the read. In that cycle ram_data_addr=up_data_addr, ram_write_m=0, and there is no drain.
- Drain: when up_read_m=0 and count>0, drive ram_write_m=1, ram_data_addr=head.addr and ram_out_m=head.data, then pop the head on the clock edge. One drain per cycle at most.
- Idle: ram_write_m=0 and ram_data_addr=up_data_addr.
- Read forwarding: up_in_m is combinational. The youngest valid entry whose addr equals up_data_addr supplies its data.
- If up_write_m && up_read_m, the read returns up_out_m, with priority over buffered entries.
- If nothing matches, up_in_m=ram_in_m. Upstream holds address and read for 2 or more cycles on a miss, and the RAM port stays on that address for all cycles up_read_m is high.
- Simultaneous enqueue and drain: count is unchanged, and both pointers advance.
- Ordering: the RAM sees writes in acceptance order. A drain never overtakes a younger write to the same address.
- wb_empty = (count==0) and wb_count = count, both registered.

Optional Feature:
Macro WB_COALESCE_EN.
- Defined: a write whose address matches a valid entry overwrites that entry's data in place. Count is unchanged and the write is accepted even when full (up_stall=0).
- Exception: if the matching entry is the head being drained in that cycle, the write is enqueued normally and stalls if full.
- With coalescing, at most one entry per address exists.
- Undefined: every accepted write takes a new entry, and duplicates are allowed. Forwarding still picks the youngest match.

Test Plan:
- Reset, then write 0x1234@0x010 with no reads -> next cycle ram_write_m=1, ram_data_addr=0x010, ram_out_m=0x1234; wb_count back to 0 after the drain edge.
- Hold up_read_m=1 while 4 writes arrive (A0..A3) then a 5th -> 5th sees up_stall=1, wb_count=4. Drop read -> 4 drains in order A0..A3 over 4 cycles, and the 5th is accepted the cycle after the first drain.
- Write 0xAAAA@0x020, then 0xBBBB@0x020 while reading is held, then read 0x020 -> up_in_m=0xBBBB with no RAM access. Without WB_COALESCE_EN, wb_count=2. With it, wb_count=1 and RAM sees only 0xBBBB.
- Read of 0x300 not in the buffer, with RAM preloaded to 0x5A5A -> ram_data_addr=0x300, ram_write_m=0 for both cycles, and up_in_m=0x5A5A on the second cycle.
- Same-cycle write 0x7777@0x040 plus read 0x040 -> up_in_m=0x7777 combinationally, and the entry is enqueued.
- Assert resetN low mid-drain with wb_count=3 -> ram_write_m=0, wb_empty=1 and wb_count=0 immediately; no further RAM writes occur after release.
